// File: rtl/mem_loader.sv
// Streams a program image into a word memory, then releases the CPU and times its run.
// Optional LOADER_ZERO_FILL_EN: zero the memory above the image before starting the CPU.
module mem_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  input  logic              finish,
  output logic [ADDR_W:0]   load_count,
  output logic [31:0]       cycle_count,
  output logic              trunc_err
);

`ifdef LOADER_ZERO_FILL_EN
  typedef enum logic [1:0] {LOAD, CLEAR, RUN, DONE} state_t;
  logic [ADDR_W:0] clr_addr;
`else
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
`endif

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] FULL     = (ADDR_W+1)'(DEPTH);

  state_t          state;
  logic            accept, end_load, fin;
  logic [ADDR_W:0] cnt_nxt;

  assign accept   = in_valid & in_ready;
  assign end_load = in_last | (load_count == LAST_IDX);
  assign cnt_nxt  = load_count + 1'b1;
  // An unknown halt line must never stop the run.
  assign fin      = (finish === 1'b1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= LOAD;
      in_ready    <= 1'b1;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_start   <= 1'b0;
      load_count  <= '0;
      cycle_count <= '0;
      trunc_err   <= 1'b0;
`ifdef LOADER_ZERO_FILL_EN
      clr_addr    <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        LOAD: if (accept) begin
          mem_we     <= 1'b1;
          mem_addr   <= load_count[ADDR_W-1:0];
          mem_wdata  <= in_data;
          load_count <= cnt_nxt;
          if (end_load) begin
            in_ready <= 1'b0;
            if (!in_last) trunc_err <= 1'b1;
`ifdef LOADER_ZERO_FILL_EN
            if (cnt_nxt == FULL) state <= RUN;
            else begin
              state    <= CLEAR;
              clr_addr <= cnt_nxt;
            end
`else
            state <= RUN;
`endif
          end
        end
`ifdef LOADER_ZERO_FILL_EN
        CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= clr_addr[ADDR_W-1:0];
          mem_wdata <= '0;
          clr_addr  <= clr_addr + 1'b1;
          if (clr_addr == LAST_IDX) state <= RUN;
        end
`endif
        // First RUN cycle only raises cpu_start, so the final write lands before the CPU runs.
        RUN: begin
          if (!cpu_start)                cpu_start   <= 1'b1;
          else if (fin)                  state       <= DONE;
          else if (cycle_count != '1)    cycle_count <= cycle_count + 1'b1;
        end
        DONE: ;
        default: state <= LOAD;
      endcase
    end
  end

`ifndef LOADER_ZERO_FILL_EN
  logic unused_full;
  assign unused_full = |FULL;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: accepted words queue expected writes, the write monitor pops them.
module tb_mem_loader;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          CLK = 1'b0;
  logic          RESET, in_valid, in_ready, in_last, mem_we, cpu_start, finish, trunc_err;
  logic [31:0]   in_data, mem_wdata, cycle_count;
  logic [AW-1:0] mem_addr;
  logic [AW:0]   load_count;

  typedef struct { logic [AW-1:0] addr; logic [31:0] data; } wr_t;
  wr_t sb[$];
  int passed = 0, total = 0, exp_addr = 0;

  mem_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_start(cpu_start), .finish(finish), .load_count(load_count),
    .cycle_count(cycle_count), .trunc_err(trunc_err));

  always #5 CLK = ~CLK;

  // Write monitor: checks last edge's write, then records this cycle's handshake.
  always @(negedge CLK) begin
    if (mem_we === 1'b1) begin
      total++;
      if (sb.size() == 0)
        $display("FAIL sb_unexpected_write: addr=%0d data=%h, expected no write", mem_addr, mem_wdata);
      else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data)
          $display("FAIL sb_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        else passed++;
      end
    end
    if (RESET) begin
      sb.delete();
      exp_addr = 0;
    end else if (in_valid && in_ready === 1'b1) begin
      wr_t e;
      e.addr = AW'(exp_addr);
      e.data = in_data;
      sb.push_back(e);
      exp_addr++;
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic do_reset();
    RESET = 1; in_valid = 0; in_last = 0; in_data = '0; finish = 0;
    step();
    RESET = 0;
  endtask

  task automatic push_zeros(input int from);
`ifdef LOADER_ZERO_FILL_EN
    for (int a = from; a < DEPTH; a++) begin
      wr_t e;
      e.addr = AW'(a);
      e.data = '0;
      sb.push_back(e);
    end
`else
    if (from < 0) $display("bad zero-fill start %0d", from);
`endif
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (cpu_start !== 1'b1 && n < 2000) begin step(); n++; end
  endtask

  task automatic test_reset();
    RESET = 1; in_valid = 0; in_last = 0; in_data = '0; finish = 0;
    step(); step();
    total++;
    if ({in_ready, mem_we, cpu_start, trunc_err} !== 4'b1000)
      $display("FAIL reset_flags: got %b, expected 1000", {in_ready, mem_we, cpu_start, trunc_err});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata, load_count, cycle_count} !== '0)
      $display("FAIL reset_values: got addr=%0d wdata=%h lc=%0d cc=%0d, expected all 0",
               mem_addr, mem_wdata, load_count, cycle_count);
    else passed++;
    RESET = 0;
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    in_valid = 1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_data = 32'h33; in_last = 1; step();
    in_valid = 0; in_last = 0;
    total++;
    if ({mem_we, in_ready, cpu_start} !== 3'b100 || load_count !== 10'd3)
      $display("FAIL basic_last_write: got we/rdy/start=%b lc=%0d, expected 100 lc=3",
               {mem_we, in_ready, cpu_start}, load_count);
    else passed++;
`ifdef LOADER_ZERO_FILL_EN
    push_zeros(3);
    wait_start(n);
    total++;
    if (cpu_start !== 1'b1 || n != 510)
      $display("FAIL zero_fill_start: got start=%b after %0d cycles, expected 1 after 510", cpu_start, n);
    else passed++;
`else
    step(); n = 1;
    total++;
    if (cpu_start !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL basic_start: got start=%b we=%b after %0d cycle, expected start=1 we=0", cpu_start, mem_we, n);
    else passed++;
`endif
    total++;
    if (load_count !== 10'd3 || sb.size() != 0)
      $display("FAIL basic_done: got lc=%0d pending=%0d, expected lc=3 pending=0", load_count, sb.size());
    else passed++;
  endtask

  task automatic test_run();
    int n, bad;
    do_reset();
    finish = 1;
    step(); step(); step();
    in_valid = 1; in_data = 32'h5; in_last = 1; step();
    in_valid = 0; in_last = 0; finish = 0;
    total++;
    if (mem_we !== 1'b1 || load_count !== 10'd1)
      $display("FAIL run_finish_in_load: got we=%b lc=%0d, expected we=1 lc=1", mem_we, load_count);
    else passed++;
    push_zeros(1);
    wait_start(n);
    total++;
    if (cpu_start !== 1'b1 || cycle_count !== 32'd0)
      $display("FAIL run_start: got start=%b cc=%0d after %0d cycles, expected start=1 cc=0", cpu_start, cycle_count, n);
    else passed++;
    repeat (100) step();
    total++;
    if (cycle_count !== 32'd100)
      $display("FAIL run_count: got %0d, expected 100", cycle_count);
    else passed++;
    finish = 1; step(); finish = 0;
    total++;
    if (cycle_count !== 32'd100)
      $display("FAIL run_finish_cycle: got %0d, expected 100", cycle_count);
    else passed++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      finish = i[0];
      step();
      if (cycle_count !== 32'd100 || cpu_start !== 1'b1 || load_count !== 10'd1) bad++;
    end
    finish = 0;
    total++;
    if (bad != 0) $display("FAIL done_hold: got %0d bad cycles, expected 0", bad);
    else passed++;
  endtask

  task automatic test_toggle();
    int bad, n;
    logic acc;
    do_reset();
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 32'hA000 + i;
      in_last  = (i == 14);
      acc = in_valid && in_ready;
      step();
      if (mem_we !== acc) bad++;
    end
    in_valid = 0; in_last = 0;
    push_zeros(8);
    total++;
    if (bad != 0) $display("FAIL toggle_pulse: got %0d misaligned pulses, expected 0", bad);
    else passed++;
    wait_start(n);
    total++;
    if (cpu_start !== 1'b1 || load_count !== 10'd8 || sb.size() != 0)
      $display("FAIL toggle_done: got start=%b lc=%0d pending=%0d after %0d, expected 1 8 0",
               cpu_start, load_count, sb.size(), n);
    else passed++;
  endtask

  task automatic test_trunc();
    int bad, n;
    do_reset();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1; in_last = 0; in_data = i * 7 + 3;
      if (in_ready !== 1'b1) bad++;
      step();
    end
    total++;
    if (bad != 0) $display("FAIL trunc_ready: got %0d stalls, expected 0", bad);
    else passed++;
    total++;
    if ({trunc_err, in_ready, mem_we} !== 3'b101 || load_count !== 10'd512 || mem_addr !== 9'd511)
      $display("FAIL trunc_end: got err/rdy/we=%b lc=%0d addr=%0d, expected 101 lc=512 addr=511",
               {trunc_err, in_ready, mem_we}, load_count, mem_addr);
    else passed++;
    in_data = 32'hDEAD; in_last = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (mem_we !== 1'b0) bad++;
    end
    in_valid = 0; in_last = 0;
    total++;
    if (bad != 0 || load_count !== 10'd512)
      $display("FAIL trunc_513th: got %0d writes lc=%0d, expected 0 writes lc=512", bad, load_count);
    else passed++;
    wait_start(n);
    total++;
    if (cpu_start !== 1'b1 || trunc_err !== 1'b1 || sb.size() != 0)
      $display("FAIL trunc_run: got start=%b err=%b pending=%0d after %0d, expected 1 1 0",
               cpu_start, trunc_err, sb.size(), n);
    else passed++;
  endtask

  task automatic test_reset_run();
    int n;
    do_reset();
    in_valid = 1; in_data = 32'h77; in_last = 1; step();
    in_valid = 0; in_last = 0;
    push_zeros(1);
    wait_start(n);
    finish = 1'bx;
    repeat (57) step();
    total++;
    if (cycle_count !== 32'd57)
      $display("FAIL rr_count_x: got %0d, expected 57", cycle_count);
    else passed++;
    RESET = 1; finish = 1; in_valid = 1; in_data = 32'h1; step();
    total++;
    if ({in_ready, mem_we, cpu_start, trunc_err} !== 4'b1000)
      $display("FAIL rr_reset_flags: got %b, expected 1000", {in_ready, mem_we, cpu_start, trunc_err});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata, load_count, cycle_count} !== '0)
      $display("FAIL rr_reset_values: got addr=%0d wdata=%h lc=%0d cc=%0d, expected all 0",
               mem_addr, mem_wdata, load_count, cycle_count);
    else passed++;
    RESET = 0; finish = 0; in_data = 32'hABCD; in_last = 1; step();
    in_valid = 0; in_last = 0;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 9'd0 || load_count !== 10'd1)
      $display("FAIL rr_reload: got we=%b addr=%0d lc=%0d, expected 1 0 1", mem_we, mem_addr, load_count);
    else passed++;
    push_zeros(1);
    wait_start(n);
    total++;
    if (cpu_start !== 1'b1 || cycle_count !== 32'd0 || sb.size() != 0)
      $display("FAIL rr_restart: got start=%b cc=%0d pending=%0d after %0d, expected 1 0 0",
               cpu_start, cycle_count, sb.size(), n);
    else passed++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_run();
    test_toggle();
    test_trunc();
    test_reset_run();
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
